// File: rtl/nwd_arbiter_if.sv
// Requester-side and core-side signals of the nwd_arbiter bundled together.
// slave is the arbiter's view; master is the requesters' and the core's view.
interface nwd_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] opa;
  logic [N*W-1:0] opb;
  logic [N-1:0]   done;
  logic [W-1:0]   res;
  logic [IDW-1:0] res_id;
  logic           busy;
  logic           core_start;
  logic [W-1:0]   core_ina;
  logic [W-1:0]   core_inb;
  logic           core_ready;
  logic [W-1:0]   core_out;

  modport slave (
    input  req, opa, opb, core_ready, core_out,
    output done, res, res_id, busy, core_start, core_ina, core_inb
  );

  modport master (
    output req, opa, opb, core_ready, core_out,
    input  done, res, res_id, busy, core_start, core_ina, core_inb
  );
endinterface

// File: rtl/nwd_arbiter.sv
// Round-robin scheduler sharing one nwd GCD core among N requesters.
// Optional feature: NWD_ARB_ZERO_BYPASS_EN answers zero-operand requests without the core.
module nwd_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           nrst,
  nwd_arbiter_if.slave   bus,
  output logic [1:0]     dbg_state
);
  localparam int IDW = $clog2(N);

  // Handshakes: a requester holds req high with stable operands until its
  // one-cycle done pulse; the core is started by a one-cycle core_start
  // and signals completion by raising core_ready.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic [W-1:0]   opa_sel, opb_sel;
  logic [N-1:0]   done_n;
  logic [W-1:0]   res_n;
  logic [IDW-1:0] res_id_n;
  logic [W-1:0]   ina_n, inb_n;
  logic           start_n;
  logic [N-1:0]   owner_onehot;
  int             scan_j;

  // Scan upward from ptr, wrapping modulo N, for the first pending request.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_j      = 0;
    for (int k = 0; k < N; k++) begin
      scan_j = int'(ptr) + k;
      if (scan_j >= N) scan_j = scan_j - N;
      if (!grant_found && bus.req[scan_j]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(scan_j);
      end
    end
  end

  assign opa_sel      = bus.opa[grant_idx*W +: W];
  assign opb_sel      = bus.opb[grant_idx*W +: W];
  assign owner_onehot = {{(N-1){1'b0}}, 1'b1} << bus.res_id;

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    done_n   = '0;
    res_n    = bus.res;
    res_id_n = bus.res_id;
    ina_n    = bus.core_ina;
    inb_n    = bus.core_inb;
    start_n  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found && bus.core_ready) begin
          res_id_n = grant_idx;
          ina_n    = opa_sel;
          inb_n    = opb_sel;
          ptr_n    = (grant_idx == IDW'(N-1)) ? '0 : grant_idx + 1'b1;
`ifdef NWD_ARB_ZERO_BYPASS_EN
          if (opa_sel == '0 || opb_sel == '0) begin
            res_n   = opa_sel | opb_sel;
            state_n = RESP;
          end else begin
            start_n = 1'b1;
            state_n = LAUNCH;
          end
`else
          start_n = 1'b1;
          state_n = LAUNCH;
`endif
        end
      end
      LAUNCH: state_n = WAIT;
      WAIT: begin
        if (bus.core_ready) begin
          res_n   = bus.core_out;
          done_n  = owner_onehot;
          state_n = RESP;
        end
      end
      RESP: begin
`ifdef NWD_ARB_ZERO_BYPASS_EN
        // A bypassed request enters RESP without done; raise it one cycle later.
        if (bus.done == '0) done_n = owner_onehot;
        else                state_n = IDLE;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      ptr            <= '0;
      bus.done       <= '0;
      bus.res        <= '0;
      bus.res_id     <= '0;
      bus.core_start <= 1'b0;
      bus.core_ina   <= '0;
      bus.core_inb   <= '0;
    end else begin
      state          <= state_n;
      ptr            <= ptr_n;
      bus.done       <= done_n;
      bus.res        <= res_n;
      bus.res_id     <= res_id_n;
      bus.core_start <= start_n;
      bus.core_ina   <= ina_n;
      bus.core_inb   <= inb_n;
    end
  end

  assign bus.busy  = (state != IDLE);
  assign dbg_state = state;
endmodule

// File: tb/tb_nwd_arbiter.sv
// Directed bench for nwd_arbiter with a behavioural subtract/swap GCD core.
module tb_nwd_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  nwd_arbiter_if #(.N(N), .W(W)) bus ();
  logic [1:0] dbg_state;

  nwd_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Core model: start loads operands and drops ready; one SUB or SWAP per cycle.
  logic [W-1:0] c_a, c_b, c_out;
  logic         c_ready, c_run;
  logic         hold_nr = 1'b0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      c_a <= '0; c_b <= '0; c_out <= '0; c_ready <= 1'b1; c_run <= 1'b0;
    end else if (bus.core_start) begin
      c_a <= bus.core_ina; c_b <= bus.core_inb; c_ready <= 1'b0; c_run <= 1'b1;
    end else if (c_run) begin
      if (c_a == c_b) begin
        c_out <= c_a; c_ready <= 1'b1; c_run <= 1'b0;
      end else if (c_a < c_b) begin
        c_a <= c_b; c_b <= c_a;
      end else begin
        c_a <= c_a - c_b;
      end
    end
  end

  assign bus.core_ready = c_ready & ~hold_nr;
  assign bus.core_out   = c_out;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  always @(posedge clk) if (bus.core_start === 1'b1) n_start++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.opa[i*W +: W] = a;
    bus.opb[i*W +: W] = b;
    bus.req[i] = 1'b1;
  endtask

  task automatic wait_done(input string tag, input logic [N-1:0] exp_done, input logic [W-1:0] exp_res);
    int k;
    k = 0;
    while (bus.done == '0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
    check({tag, "_res"}, 32'(bus.res), 32'(exp_res));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   32'(bus.busy), 32'h0);
    check({tag, "_done"},   32'(bus.done), 32'h0);
    check({tag, "_res"},    32'(bus.res), 32'h0);
    check({tag, "_res_id"}, 32'(bus.res_id), 32'h0);
    check({tag, "_start"},  32'(bus.core_start), 32'h0);
    check({tag, "_ina"},    32'(bus.core_ina), 32'h0);
    check({tag, "_inb"},    32'(bus.core_inb), 32'h0);
    check({tag, "_state"},  32'(dbg_state), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          order [6];
  logic [W-1:0] rr_res [N];
  int          starts_before;

  initial begin
    order  = '{0, 1, 3, 0, 1, 3};
    rr_res = '{8'd4, 8'd5, 8'd0, 8'd7};
    bus.req = '0;
    bus.opa = '0;
    bus.opb = '0;

    // Reset values
    tick(2);
    check_reset_outputs("rst");
    nrst = 1'b1;
    tick(1);

    // Single request: 12,8 on requester 1, n=3
    set_req(1, 8'd12, 8'd8);
    tick(1);
    check("single_busy",   32'(bus.busy), 32'h1);
    check("single_start",  32'(bus.core_start), 32'h1);
    check("single_res_id", 32'(bus.res_id), 32'h1);
    check("single_ina",    32'(bus.core_ina), 32'd12);
    check("single_inb",    32'(bus.core_inb), 32'd8);
    tick(1);
    check("single_start_e1", 32'(bus.core_start), 32'h0);
    tick(4);
    check("single_done_e5", 32'(bus.done), 32'h0);
    tick(1);
    check("single_done_e6", 32'(bus.done), 32'b0010);
    check("single_res",     32'(bus.res), 32'd4);
    check("single_id_e6",   32'(bus.res_id), 32'h1);
    bus.req[1] = 1'b0;
    tick(1);
    check("single_done_off", 32'(bus.done), 32'h0);
    check("single_idle",     32'(bus.busy), 32'h0);
    check("single_res_hold", 32'(bus.res), 32'd4);
    check("single_nstart",   32'(n_start), 32'd1);

    // Equal operands on requester 2: done after E3
    set_req(2, 8'd9, 8'd9);
    tick(3);
    check("equal_done_e2", 32'(bus.done), 32'h0);
    tick(1);
    check("equal_done_e3", 32'(bus.done), 32'b0100);
    check("equal_res",     32'(bus.res), 32'd9);
    check("equal_res_id",  32'(bus.res_id), 32'd2);
    bus.req[2] = 1'b0;
    tick(1);

    // Core not ready: request must wait in IDLE
    starts_before = n_start;
    hold_nr = 1'b1;
    set_req(0, 8'd6, 8'd4);
    tick(3);
    check("nr_busy",   32'(bus.busy), 32'h0);
    check("nr_start",  32'(bus.core_start), 32'h0);
    check("nr_nstart", 32'(n_start), 32'(starts_before));
    hold_nr = 1'b0;
    tick(1);
    check("nr_grant_busy", 32'(bus.busy), 32'h1);
    check("nr_grant_id",   32'(bus.res_id), 32'h0);
    check("nr_grant_start", 32'(bus.core_start), 32'h1);
    wait_done("nr", 4'b0001, 8'd2);
    bus.req[0] = 1'b0;
    tick(1);

    // Reset in WAIT; afterwards requester 0 wins over 3 (ptr would be 3 otherwise)
    set_req(2, 8'd20, 8'd15);
    tick(3);
    check("mid_state_wait", 32'(dbg_state), 32'd2);
    check("mid_res_id",     32'(bus.res_id), 32'd2);
    nrst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    bus.req = '0;
    @(negedge clk);
    set_req(0, 8'd12, 8'd8);
    set_req(1, 8'd15, 8'd10);
    set_req(3, 8'd7, 8'd7);
    nrst = 1'b1;
    tick(1);
    check("rr_first_busy", 32'(bus.busy), 32'h1);
    check("rr_first_id",   32'(bus.res_id), 32'h0);

    // Round-robin with 4'b1011 held and immediate re-requests
    for (int i = 0; i < 6; i++) begin
      wait_done($sformatf("rr%0d", i), 4'(1 << order[i]), rr_res[order[i]]);
      check($sformatf("rr%0d_id", i), 32'(bus.res_id), 32'(order[i]));
      bus.req[order[i]] = 1'b0;
      if (i == 5) bus.req = '0;
      tick(1);
      check($sformatf("rr%0d_done_off", i), 32'(bus.done), 32'h0);
      if (i < 5) begin
        bus.req[order[i]] = 1'b1;
        tick(1);
        check($sformatf("rr%0d_next_busy", i), 32'(bus.busy), 32'h1);
        check($sformatf("rr%0d_next_id", i),   32'(bus.res_id), 32'(order[i+1]));
      end
    end
    tick(1);
    check("rr_end_idle", 32'(bus.busy), 32'h0);

    // Zero operand on requester 0
    starts_before = n_start;
    set_req(0, 8'd0, 8'd15);
    tick(1);
`ifdef NWD_ARB_ZERO_BYPASS_EN
    check("zero_start_e0", 32'(bus.core_start), 32'h0);
    check("zero_res_e0",   32'(bus.res), 32'd15);
    check("zero_done_e0",  32'(bus.done), 32'h0);
    tick(1);
    check("zero_done_e1",  32'(bus.done), 32'b0001);
    check("zero_res_e1",   32'(bus.res), 32'd15);
    bus.req[0] = 1'b0;
    tick(1);
    check("zero_done_off", 32'(bus.done), 32'h0);
    check("zero_nstart",   32'(n_start), 32'(starts_before));
`else
    check("zero_start_e0", 32'(bus.core_start), 32'h1);
    check("zero_busy_e0",  32'(bus.busy), 32'h1);
    tick(3);
    check("zero_nstart",   32'(n_start), 32'(starts_before + 1));
    check("zero_no_done",  32'(bus.done), 32'h0);
    // The core never terminates on a single zero; reset to abort.
    bus.req[0] = 1'b0;
    nrst = 1'b0;
    #1;
    check("zero_abort_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
`endif
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
